// File: rtl/activation_function.sv
// Streaming element-wise activation unit (AXI4-Stream in/out).
// The output register is backed by one skid entry so that s_axis_tready can be
// a flop without ever dropping a beat.
module activation_function #(
   parameter int unsigned           DATA_WIDTH      = 32,
   parameter int unsigned           ACTIVATION_MODE = 0,
   parameter int unsigned           LEAKY_SHIFT     = 3,
   parameter logic [DATA_WIDTH-1:0] CLAMP_MAX       = DATA_WIDTH'(32'h0000_0600)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tlast,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast
);

   typedef struct packed {
      logic                  last;
      logic [DATA_WIDTH-1:0] data;
   } beat_t;

   logic signed [DATA_WIDTH-1:0] x_s;
   logic signed [DATA_WIDTH-1:0] y_c;
   logic                         is_neg_c;

   logic  in_fire_c;
   logic  out_fire_c;
   beat_t new_beat_c;

   beat_t skid_q;
   beat_t skid_d;
   logic  skid_valid_q;
   logic  skid_valid_d;
   beat_t out_d;
   logic  out_valid_d;
   logic  s_ready_d;

   // Nonlinearity on the incoming word; negativity is the sign bit alone.
   always_comb begin
      x_s      = $signed(s_axis_tdata);
      is_neg_c = s_axis_tdata[DATA_WIDTH-1];
      y_c      = x_s;
      case (ACTIVATION_MODE)
         32'd0: begin
            if (is_neg_c) y_c = '0;
         end
         32'd1: begin
            if (is_neg_c) y_c = x_s >>> LEAKY_SHIFT;
         end
         32'd2: begin
            if (is_neg_c)                    y_c = '0;
            else if (x_s > $signed(CLAMP_MAX)) y_c = $signed(CLAMP_MAX);
         end
         default: y_c = x_s;
      endcase
   end

   // Handshake decode and next state of the output/skid pair.
   always_comb begin
      in_fire_c    = s_axis_tvalid & s_axis_tready;
      out_fire_c   = m_axis_tvalid & m_axis_tready;
      new_beat_c   = '{last: s_axis_tlast, data: DATA_WIDTH'(y_c)};
      out_d        = '{last: m_axis_tlast, data: m_axis_tdata};
      out_valid_d  = m_axis_tvalid;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;

      if (skid_valid_q) begin
         // Input is closed while the skid is full; only draining moves data.
         if (out_fire_c) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end
      end else if (in_fire_c) begin
         if (!m_axis_tvalid || out_fire_c) begin
            out_d       = new_beat_c;
            out_valid_d = 1'b1;
         end else begin
            skid_d       = new_beat_c;
            skid_valid_d = 1'b1;
         end
      end else if (out_fire_c) begin
         out_valid_d = 1'b0;
      end

      s_ready_d = ~skid_valid_d;
   end

   // State registers; tready comes up on the first edge after reset release.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         s_axis_tready <= 1'b0;
         skid_valid_q  <= 1'b0;
         skid_q        <= '0;
      end else begin
         m_axis_tvalid <= out_valid_d;
         m_axis_tdata  <= out_d.data;
         m_axis_tlast  <= out_d.last;
         s_axis_tready <= s_ready_d;
         skid_valid_q  <= skid_valid_d;
         skid_q        <= skid_d;
      end
   end

endmodule

// File: tb/tb_activation_function.sv
// Bench for activation_function: ReLU instance checked through a scoreboard,
// leaky and clamped instances checked directly against vector tables.
module tb_activation_function;

   localparam int unsigned W = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic         s_valid, s_ready, s_last, m_valid, m_ready, m_last;
   logic [W-1:0] s_data, m_data, s_exp;

   logic         s1_valid, s1_ready, s1_last, m1_valid, m1_last;
   logic [W-1:0] s1_data, m1_data;
   logic         s2_valid, s2_ready, s2_last, m2_valid, m2_last;
   logic [W-1:0] s2_data, m2_data;

   activation_function #(.DATA_WIDTH(W), .ACTIVATION_MODE(0)) dut0 (
      .clk(clk), .reset(reset),
      .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tdata(s_data), .s_axis_tlast(s_last),
      .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tdata(m_data), .m_axis_tlast(m_last));

   activation_function #(.DATA_WIDTH(W), .ACTIVATION_MODE(1), .LEAKY_SHIFT(3)) dut1 (
      .clk(clk), .reset(reset),
      .s_axis_tvalid(s1_valid), .s_axis_tready(s1_ready), .s_axis_tdata(s1_data), .s_axis_tlast(s1_last),
      .m_axis_tvalid(m1_valid), .m_axis_tready(1'b1), .m_axis_tdata(m1_data), .m_axis_tlast(m1_last));

   activation_function #(.DATA_WIDTH(W), .ACTIVATION_MODE(2), .CLAMP_MAX(32'h0000_0600)) dut2 (
      .clk(clk), .reset(reset),
      .s_axis_tvalid(s2_valid), .s_axis_tready(s2_ready), .s_axis_tdata(s2_data), .s_axis_tlast(s2_last),
      .m_axis_tvalid(m2_valid), .m_axis_tready(1'b1), .m_axis_tdata(m2_data), .m_axis_tlast(m2_last));

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      logic [W-1:0] data;
      logic         last;
   } beat_t;

   beat_t  exp_q[$];
   beat_t  mon_e;
   int     out_cyc[$];
   logic   mon_en = 1'b0;
   logic   rnd_en = 1'b0;
   logic   stall_prev = 1'b0;
   logic [W-1:0] prev_data;
   logic         prev_last;

   typedef struct {
      logic [W-1:0] data;
      logic         last;
      logic [W-1:0] exp;
   } vec_t;

   typedef struct {
      int unsigned  mode;
      logic [W-1:0] data;
      logic [W-1:0] exp;
   } mvec_t;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] relu(input logic [W-1:0] x);
      return x[W-1] ? '0 : x;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: pop/compare on output transfer, push on input accept.
   always @(negedge clk) begin
      if (!mon_en) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("hold_valid", W'(m_valid), W'(1));
            chk("hold_data", m_data, prev_data);
            chk("hold_last", W'(m_last), W'(prev_last));
         end
         if (m_valid && m_ready) begin
            out_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: got %h expected no beat", m_data);
            end else begin
               mon_e = exp_q.pop_front();
               chk("sb_data", m_data, mon_e.data);
               chk("sb_last", W'(m_last), W'(mon_e.last));
            end
         end
         if (s_valid && s_ready) begin
            mon_e.data = s_exp;
            mon_e.last = s_last;
            exp_q.push_back(mon_e);
         end
         stall_prev = m_valid && !m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
      end
   end

   always @(posedge clk) begin
      if (rnd_en) begin
         #1;
         m_ready = 1'($urandom_range(0, 1));
      end
   end

   // Holds s_valid until accepted; entered and left just after a rising edge.
   task automatic wait_accept(input string name);
      int n = 0;
      @(negedge clk);
      while (!s_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no accept expected accept", name);
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic send(input logic [W-1:0] d, input logic l, input logic [W-1:0] e);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      s_exp   = e;
      wait_accept("send");
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || m_valid) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_empty", W'(exp_q.size()), W'(0));
      @(posedge clk);
      #1;
   endtask

   task automatic direct(input int unsigned mode, input logic [W-1:0] d, input logic [W-1:0] e);
      if (mode == 1) begin
         s1_valid = 1'b1; s1_data = d; s1_last = d[0];
      end else begin
         s2_valid = 1'b1; s2_data = d; s2_last = d[0];
      end
      @(posedge clk);
      #1;
      s1_valid = 1'b0;
      s2_valid = 1'b0;
      if (mode == 1) begin
         chk("m1_valid", W'(m1_valid), W'(1));
         chk("m1_data", m1_data, e);
         chk("m1_last", W'(m1_last), W'(d[0]));
      end else begin
         chk("m2_valid", W'(m2_valid), W'(1));
         chk("m2_data", m2_data, e);
         chk("m2_last", W'(m2_last), W'(d[0]));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t  vecs[6];
      mvec_t mvecs[8];
      logic [W-1:0] rd;

      vecs[0] = '{32'h8000_0010, 1'b1, 32'h0000_0000};
      vecs[1] = '{32'hFFFF_FFF0, 1'b0, 32'h0000_0000};
      vecs[2] = '{32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF};
      vecs[3] = '{32'h0000_0000, 1'b1, 32'h0000_0000};
      vecs[4] = '{32'h8000_0000, 1'b0, 32'h0000_0000};
      vecs[5] = '{32'h0000_0001, 1'b1, 32'h0000_0001};

      mvecs[0] = '{1, 32'hFFFF_FF80, 32'hFFFF_FFF0};
      mvecs[1] = '{1, 32'h0000_0041, 32'h0000_0041};
      mvecs[2] = '{1, 32'h8000_0000, 32'hF000_0000};
      mvecs[3] = '{2, 32'h0000_1000, 32'h0000_0600};
      mvecs[4] = '{2, 32'h0000_0100, 32'h0000_0100};
      mvecs[5] = '{2, 32'hFFFF_FFFF, 32'h0000_0000};
      mvecs[6] = '{2, 32'h0000_0601, 32'h0000_0600};
      mvecs[7] = '{2, 32'h0000_0600, 32'h0000_0600};

      reset   = 1'b0;
      s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_exp = '0;
      m_ready = 1'b1;
      s1_valid = 1'b0; s1_data = '0; s1_last = 1'b0;
      s2_valid = 1'b0; s2_data = '0; s2_last = 1'b0;

      // Reset values and tready rising on the first edge after release.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_m_valid", W'(m_valid), W'(0));
      chk("rst_m_data", m_data, '0);
      chk("rst_m_last", W'(m_last), W'(0));
      chk("rst_s_ready", W'(s_ready), W'(0));
      #2;
      reset = 1'b1;
      @(negedge clk);
      chk("ready_before_edge", W'(s_ready), W'(0));
      @(posedge clk);
      #1;
      chk("ready_after_edge", W'(s_ready), W'(1));
      mon_en = 1'b1;

      // One-cycle latency.
      chk("idle_m_valid", W'(m_valid), W'(0));
      send(32'h0000_0010, 1'b0, 32'h0000_0010);
      chk("lat_m_valid", W'(m_valid), W'(1));
      chk("lat_m_data", m_data, 32'h0000_0010);
      chk("lat_m_last", W'(m_last), W'(0));
      drain();

      // ReLU vector table, back to back.
      for (int i = 0; i < 6; i++) send(vecs[i].data, vecs[i].last, vecs[i].exp);
      drain();

      // Backpressure: 1 in output, 2 in skid, 3 waiting.
      m_ready = 1'b0;
      send(32'h1, 1'b0, 32'h1);
      send(32'h2, 1'b0, 32'h2);
      s_valid = 1'b1; s_data = 32'h3; s_last = 1'b1; s_exp = 32'h3;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("bp_m_valid", W'(m_valid), W'(1));
      chk("bp_m_data", m_data, 32'h1);
      chk("bp_s_ready", W'(s_ready), W'(0));
      m_ready = 1'b1;
      wait_accept("bp");
      drain();

      // Eight-beat stream at full rate, tlast on the last beat.
      out_cyc.delete();
      for (int i = 0; i < 8; i++) send(W'(32'h100 + i), (i == 7), W'(32'h100 + i));
      drain();
      chk("stream_count", W'(out_cyc.size()), W'(8));
      if (out_cyc.size() == 8) chk("stream_span", W'(out_cyc[7] - out_cyc[0]), W'(7));

      // Random data under random backpressure.
      rnd_en = 1'b1;
      for (int i = 0; i < 24; i++) begin
         rd = $urandom;
         send(rd, 1'($urandom_range(0, 1)), relu(rd));
      end
      rnd_en = 1'b0;
      @(posedge clk);
      #2;
      m_ready = 1'b1;
      drain();

      // Leaky and clamped builds.
      for (int i = 0; i < 8; i++) direct(mvecs[i].mode, mvecs[i].data, mvecs[i].exp);

      // Reset with output valid and skid full.
      m_ready = 1'b0;
      send(32'h21, 1'b1, 32'h21);
      send(32'h22, 1'b0, 32'h22);
      chk("pre_rst_s_ready", W'(s_ready), W'(0));
      chk("pre_rst_m_valid", W'(m_valid), W'(1));
      #2;
      mon_en = 1'b0;
      exp_q.delete();
      reset = 1'b0;
      #1;
      chk("mid_rst_m_valid", W'(m_valid), W'(0));
      chk("mid_rst_m_data", m_data, '0);
      chk("mid_rst_m_last", W'(m_last), W'(0));
      chk("mid_rst_s_ready", W'(s_ready), W'(0));
      @(posedge clk);
      #3;
      reset   = 1'b1;
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_m_valid", W'(m_valid), W'(0));
      mon_en = 1'b1;
      send(32'h55, 1'b1, 32'h55);
      chk("post_rst_data", m_data, 32'h55);
      chk("post_rst_last", W'(m_last), W'(1));
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
